alu_op_issue: RTL
=================

// Module: alu_op_issue
// PURPOSE
//   Producer side of the ALU control interface: decodes a MIPS instruction word into the
//   ALU's 5-bit ctrl code, selects operands and shamt, and presents them through a
//   registered 2-entry skid buffer with valid/ready handshake. Sits between the ID stage
//   (register-file read) and the ALU; output fields connect directly to src1_i/src2_i/ctrl_i/shamt.
// PARAMETERS
//   DATA_W       32  operand width
//   CTRL_W       5   ALU ctrl code width
//   ILLEGAL_CTRL 31  ctrl code emitted for unsupported instructions (ALU yields 0)
//   CNT_W        16  width of issued-op counter
// PORTS
//   clk_i           in   1        clock, rising edge
//   rst_i           in   1        asynchronous reset, active-low
//   flush_i         in   1        sync flush: discard all buffered ops
//   in_valid_i      in   1        instruction + operands valid
//   in_ready_o      out  1        buffer can accept (registered)
//   instr_i         in   32       instruction word
//   rs_data_i       in   DATA_W   register rs value
//   rt_data_i       in   DATA_W   register rt value
//   out_valid_o     out  1        head entry valid
//   out_ready_i     in   1        ALU stage accepts head
//   src1_o          out  DATA_W   to ALU src1_i
//   src2_o          out  DATA_W   to ALU src2_i
//   ctrl_o          out  CTRL_W   to ALU ctrl_i
//   shamt_o         out  5        to ALU shamt
//   illegal_o       out  1        head entry is unsupported instr (qualified by out_valid_o)
//   issued_cnt_o    out  CNT_W    count of completed output handshakes
// BEHAVIOUR
//   Decode (op=instr[31:26], funct=instr[5:0]); src1=rs_data_i always:
//     op 0x00 funct 0x20->ctrl 0 add, 0x22->2 sub, 0x24->3 and, 0x25->4 or, 0x2A->5 slt; src2=rt
//     op 0x08 ->1 addi; op 0x23 ->13 lw; op 0x2B ->14 sw; src2=sign-extend(instr[15:0])
//     other op/funct -> ctrl ILLEGAL_CTRL, illegal=1, src2=rt; shamt=instr[10:6] in all cases
//   Push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//   FSM EMPTY/ONE/TWO (entry count); in_ready_o = (state!=TWO), out_valid_o = (state!=EMPTY).
//     EMPTY: push->ONE.  ONE: push&!pop->TWO, pop&!push->EMPTY, push&pop->ONE (new entry at head).
//     TWO: pop->ONE (second entry becomes head); no push possible.
//   Latency: op accepted at edge N is visible on outputs after edge N (cycle N+1) if buffer was
//     empty; ops leave in acceptance order; head fields stable while out_valid_o & !out_ready_i.
//   flush_i=1: next state EMPTY, entries dropped, same-cycle push and pop discarded, counter not
//     incremented; flush has priority over all handshakes.
//   issued_cnt_o += 1 per pop; wraps 2^CNT_W-1 -> 0.
//   Reset (async assert, any time incl. mid-transfer): state EMPTY, in_ready_o=1, out_valid_o=0,
//     src1_o/src2_o/ctrl_o/shamt_o/illegal_o=0, issued_cnt_o=0. Release sync to clk_i.
//   Output data regs of an empty buffer hold last values (don't-care), but reset value is 0.
// STRUCTURE
//   Package alu_pkg: ctrl code localparams (ADD=0,ADDI=1,SUB=2,AND=3,OR=4,SLT=5,LW=13,SW=14,
//     ILLEGAL=31), opcode/funct constants, entry struct {src1,src2,ctrl,shamt,illegal}.
//   Sub-module alu_ctrl_decode: combinational instr -> entry; top holds FSM, 2 entry regs, counter.
// TESTING
//   Reset mid-stream with 2 entries -> next cycle out_valid_o=0, in_ready_o=1, issued_cnt_o=0.
//   Push 0x012A4020 (add $8,$9,$10), rs=5, rt=7, out_ready=1 -> next cycle ctrl=0 src1=5 src2=7.
//   Push addi imm 0xFFFC, rs=10 -> ctrl=1 src2=0xFFFFFFFC; lw/sw -> ctrl 13/14.
//   out_ready=0, push 3 ops -> third refused (in_ready_o=0), head held; release -> order 1,2,3.
//   op 0x3F -> ctrl=31, illegal_o=1; flush with 2 entries + push -> EMPTY, count unchanged.
//   Preload cnt near 0xFFFF, 2 pops -> wraps to 0x0001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue path: ctrl codes, MIPS opcode/funct
// values and the buffered-entry layout handed to the ALU.
package alu_pkg;

  localparam int ALU_DATA_W  = 32;
  localparam int ALU_CTRL_W  = 5;
  localparam int ALU_SHAMT_W = 5;

  localparam logic [ALU_CTRL_W-1:0] CTRL_ADD     = 5'd0;
  localparam logic [ALU_CTRL_W-1:0] CTRL_ADDI    = 5'd1;
  localparam logic [ALU_CTRL_W-1:0] CTRL_SUB     = 5'd2;
  localparam logic [ALU_CTRL_W-1:0] CTRL_AND     = 5'd3;
  localparam logic [ALU_CTRL_W-1:0] CTRL_OR      = 5'd4;
  localparam logic [ALU_CTRL_W-1:0] CTRL_SLT     = 5'd5;
  localparam logic [ALU_CTRL_W-1:0] CTRL_LW      = 5'd13;
  localparam logic [ALU_CTRL_W-1:0] CTRL_SW      = 5'd14;
  localparam logic [ALU_CTRL_W-1:0] CTRL_ILLEGAL = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [ALU_DATA_W-1:0]  src1;
    logic [ALU_DATA_W-1:0]  src2;
    logic [ALU_CTRL_W-1:0]  ctrl;
    logic [ALU_SHAMT_W-1:0] shamt;
    logic                   illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fill_e;

  function automatic logic [ALU_DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{(ALU_DATA_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS instruction decode into one ALU issue entry (ctrl, operands, shamt).
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter logic [ALU_CTRL_W-1:0] ILLEGAL_CTRL = CTRL_ILLEGAL
) (
  input  logic [31:0]           instr_i,
  input  logic [ALU_DATA_W-1:0] rs_data_i,
  input  logic [ALU_DATA_W-1:0] rt_data_i,
  output entry_t                entry_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_regfields;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  // Register numbers were already consumed by the register-file read.
  assign unused_regfields = ^instr_i[25:16];

  always_comb begin
    entry_o.src1    = rs_data_i;
    entry_o.src2    = rt_data_i;
    entry_o.ctrl    = ILLEGAL_CTRL;
    entry_o.shamt   = instr_i[10:6];
    entry_o.illegal = 1'b1;
    case (op)
      OP_RTYPE: begin
        entry_o.illegal = 1'b0;
        case (funct)
          FN_ADD:  entry_o.ctrl = CTRL_ADD;
          FN_SUB:  entry_o.ctrl = CTRL_SUB;
          FN_AND:  entry_o.ctrl = CTRL_AND;
          FN_OR:   entry_o.ctrl = CTRL_OR;
          FN_SLT:  entry_o.ctrl = CTRL_SLT;
          default: entry_o.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        entry_o.illegal = 1'b0;
        entry_o.src2    = sext16(instr_i[15:0]);
        entry_o.ctrl    = (op == OP_ADDI) ? CTRL_ADDI :
                          (op == OP_LW)   ? CTRL_LW   : CTRL_SW;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// Decoded-op issue to the ALU through a 2-entry skid buffer (valid/ready both sides
// registered), plus a count of ops handed over.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int                DATA_W       = ALU_DATA_W,
  parameter int                CTRL_W       = ALU_CTRL_W,
  parameter logic [CTRL_W-1:0] ILLEGAL_CTRL = 5'd31,
  parameter int                CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [4:0]        shamt_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  issued_cnt_o
);

  fill_e            state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  entry_t           dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  alu_ctrl_decode #(.ILLEGAL_CTRL(ILLEGAL_CTRL)) u_dec (
    .instr_i  (instr_i),
    .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i),
    .entry_o  (dec)
  );

  assign in_ready_o  = (state_q != ST_TWO);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      if (pop) cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_EMPTY: if (push) begin
          head_d  = dec;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            tail_d  = dec;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign src1_o       = head_q.src1;
  assign src2_o       = head_q.src2;
  assign ctrl_o       = head_q.ctrl;
  assign shamt_o      = head_q.shamt;
  assign illegal_o    = head_q.illegal;
  assign issued_cnt_o = cnt_q;

endmodule
